// File: rtl/cpu_hazard_pkg.sv
// Shared decode-field and scoreboard constants for the CPU hazard logic.
package cpu_hazard_pkg;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;

    localparam int CNT_W_DEF = 2;
    typedef logic [CNT_W_DEF-1:0] sb_cnt_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_reg_counter.sv
// One outstanding-write counter: saturating increment, guarded decrement with
// an underflow pulse, plus nonzero/full status.
module sb_reg_counter
    import cpu_hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             nz_o,
    output logic             full_o,
    output logic             uflow_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Simultaneous inc and dec cancel out, so neither bound applies.
    always_comb begin
        cnt_d   = cnt_q;
        uflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) uflow_o = 1'b1;
            else             cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign nz_o   = |cnt_q;
    assign full_o = (cnt_q == CNT_MAX);
endmodule

// File: rtl/d_hazard_scoreboard.sv
// Decode-stage scoreboard: tracks long-latency writes per register and stalls D
// on unforwardable operands, branch-on-EX dependences and WAW counter overflow.
module d_hazard_scoreboard
    import cpu_hazard_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Instruction_IFID,
    input  logic              uses_rs1_D,
    input  logic              uses_rs2_D,
    input  logic              is_branch_D,
    input  logic              is_long_D,
    input  logic              we_D,
    input  logic              issue_valid,
    input  logic              flush_D,
    input  logic [31:0]       Instruction_IDEX,
    input  logic              we_IDEX,
    input  logic              wb_valid,
    input  logic              wb_long,
    input  logic [4:0]        wb_rd,
    output logic              stall_D,
    output logic [31:0]       pending_map,
    output logic [PERF_W-1:0] stall_cycles,
    output logic              sb_err
);
    logic [4:0] rs1, rs2, rd, rd_ex;
    assign rs1   = Instruction_IFID[RS1_MSB:RS1_LSB];
    assign rs2   = Instruction_IFID[RS2_MSB:RS2_LSB];
    assign rd    = Instruction_IFID[RD_MSB:RD_LSB];
    assign rd_ex = Instruction_IDEX[RD_MSB:RD_LSB];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instruction_IFID[31:25], Instruction_IFID[14:12],
                                 Instruction_IFID[6:0], Instruction_IDEX[31:12],
                                 Instruction_IDEX[6:0]};

    logic issue_fire, wb_fire;
    assign wb_fire    = wb_valid && wb_long && (wb_rd != REG_ZERO);
    assign issue_fire = issue_valid && !stall_D && !flush_D && we_D && is_long_D
                        && (rd != REG_ZERO);

    logic [CNT_W-1:0] cnt_w [32];
    logic [31:0] nz_w, full_w, uflow_w, eff_nz_w, inc_w, dec_w;

    assign cnt_w[0]    = '0;
    assign nz_w[0]     = 1'b0;
    assign full_w[0]   = 1'b0;
    assign uflow_w[0]  = 1'b0;
    assign eff_nz_w[0] = 1'b0;
    assign inc_w[0]    = 1'b0;
    assign dec_w[0]    = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_cnt
        assign inc_w[r] = issue_fire && (rd == 5'(r));
        assign dec_w[r] = wb_fire && (wb_rd == 5'(r));
        // A completing write is forwarded from WB, so its last count no longer blocks.
        assign eff_nz_w[r] = nz_w[r] && !(dec_w[r] && (cnt_w[r] == CNT_W'(1)));

        sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_i  (inc_w[r]),
            .dec_i  (dec_w[r]),
            .cnt_o  (cnt_w[r]),
            .nz_o   (nz_w[r]),
            .full_o (full_w[r]),
            .uflow_o(uflow_w[r])
        );
    end

    logic rs1_haz, rs2_haz, waw_haz;
    assign rs1_haz = uses_rs1_D && (rs1 != REG_ZERO)
                     && (eff_nz_w[rs1] || (is_branch_D && we_IDEX && (rd_ex == rs1)));
    assign rs2_haz = uses_rs2_D && (rs2 != REG_ZERO)
                     && (eff_nz_w[rs2] || (is_branch_D && we_IDEX && (rd_ex == rs2)));
    assign waw_haz = is_long_D && we_D && (rd != REG_ZERO) && full_w[rd];

    assign stall_D     = !rst && issue_valid && !flush_D && (rs1_haz || rs2_haz || waw_haz);
    assign pending_map = nz_w;

    logic              sb_err_q, sb_err_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        sb_err_d       = sb_err_q | (|uflow_w);
        stall_cycles_d = stall_cycles_q;
        if (stall_D && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            sb_err_q       <= sb_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb_err       = sb_err_q;
    assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Self-checking bench for d_hazard_scoreboard: a reference model pushes the
// expected outputs per cycle into a queue and each scenario task pops and compares.
module tb_d_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instruction_IFID, Instruction_IDEX, pending_map;
    logic        uses_rs1_D, uses_rs2_D, is_branch_D, is_long_D, we_D;
    logic        issue_valid, flush_D, we_IDEX, wb_valid, wb_long;
    logic [4:0]  wb_rd;
    logic        stall_D, sb_err;
    logic [15:0] stall_cycles;

    d_hazard_scoreboard #(.CNT_W(2), .PERF_W(16)) dut (
        .clk(clk), .rst(rst),
        .Instruction_IFID(Instruction_IFID), .uses_rs1_D(uses_rs1_D), .uses_rs2_D(uses_rs2_D),
        .is_branch_D(is_branch_D), .is_long_D(is_long_D), .we_D(we_D),
        .issue_valid(issue_valid), .flush_D(flush_D),
        .Instruction_IDEX(Instruction_IDEX), .we_IDEX(we_IDEX),
        .wb_valid(wb_valid), .wb_long(wb_long), .wb_rd(wb_rd),
        .stall_D(stall_D), .pending_map(pending_map),
        .stall_cycles(stall_cycles), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    wire [49:0] obs = {stall_D, pending_map, sb_err, stall_cycles};

    int          nchk = 0;
    int          nerr = 0;
    logic [49:0] exp_q[$];
    logic [49:0] e;

    int   mcnt [32];
    bit   merr;
    int   mscyc;
    logic cur_stall;

    function automatic logic [31:0] instr(input int rd, input int r1, input int r2);
        logic [4:0] a, b, c;
        a = 5'(rd); b = 5'(r1); c = 5'(r2);
        return {7'd0, c, b, 3'd0, a, 7'b0110011};
    endfunction

    function automatic logic src_haz(input logic use_s, input int s);
        int eff;
        if (!use_s || s == 0) return 1'b0;
        eff = mcnt[s];
        if (eff != 0 && wb_valid && wb_long && int'(wb_rd) == s) eff = eff - 1;
        if (eff != 0) return 1'b1;
        return is_branch_D && we_IDEX && (int'(Instruction_IDEX[11:7]) == s);
    endfunction

    function automatic logic model_stall();
        logic h;
        int   rdv;
        rdv = int'(Instruction_IFID[11:7]);
        h = src_haz(uses_rs1_D, int'(Instruction_IFID[19:15]))
          | src_haz(uses_rs2_D, int'(Instruction_IFID[24:20]))
          | (is_long_D && we_D && rdv != 0 && mcnt[rdv] == 3);
        return !rst && issue_valid && !flush_D && h;
    endfunction

    function automatic logic [31:0] model_pmap();
        logic [31:0] p;
        p = '0;
        for (int r = 1; r < 32; r++) p[r] = (mcnt[r] != 0);
        return p;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr  = 1'b0;
        mscyc = 0;
    endtask

    task automatic drive(input logic [31:0] ins, input logic u1, input logic u2,
                         input logic br, input logic lng, input logic we, input logic iv,
                         input logic fl, input logic [31:0] idex, input logic weex,
                         input logic wbv, input logic wbl, input int wbr);
        Instruction_IFID = ins; uses_rs1_D = u1; uses_rs2_D = u2; is_branch_D = br;
        is_long_D = lng; we_D = we; issue_valid = iv; flush_D = fl;
        Instruction_IDEX = idex; we_IDEX = weex;
        wb_valid = wbv; wb_long = wbl; wb_rd = 5'(wbr);
        cur_stall = model_stall();
        exp_q.push_back({cur_stall, model_pmap(), merr, 16'(mscyc)});
    endtask

    task automatic idle();
        drive(32'd0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0);
    endtask

    task automatic adv();
        logic iss, wbf;
        int   rdv, wr;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            rdv = int'(Instruction_IFID[11:7]);
            wr  = int'(wb_rd);
            iss = issue_valid && !cur_stall && !flush_D && we_D && is_long_D && rdv != 0;
            wbf = wb_valid && wb_long && wr != 0;
            if (!(iss && wbf && rdv == wr)) begin
                if (iss && mcnt[rdv] < 3) mcnt[rdv]++;
                if (wbf) begin
                    if (mcnt[wr] == 0) merr = 1'b1;
                    else mcnt[wr]--;
                end
            end
            if (cur_stall && mscyc != 65535) mscyc++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) idle();
            else drive(instr(0, 7, 0), 1, 0, 1, 0, 0, 1, 0, instr(7, 1, 2), 1, 0, 0, 0);
            #2; e = exp_q.pop_front(); nchk++;
            if (obs !== e) begin nerr++; $display("FAIL reset[%0d] got=%h exp=%h", i, obs, e); end
            nchk++;
            if (stall_D !== 1'b0) begin nerr++; $display("FAIL reset_stall got=%b exp=0", stall_D); end
            adv();
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(instr(5, 1, 0), 1, 0, 0, 1, 1, 1, 0, 32'd0, 0, 0, 0, 0);
                1, 2: drive(instr(6, 5, 1), 1, 1, 0, 0, 1, 1, 0, 32'd0, 0, 0, 0, 0);
                3: drive(instr(6, 5, 1), 1, 1, 0, 0, 1, 1, 0, 32'd0, 0, 1, 1, 5);
                default: idle();
            endcase
            #2; e = exp_q.pop_front(); nchk++;
            if (obs !== e) begin nerr++; $display("FAIL load_use[%0d] got=%h exp=%h", i, obs, e); end
            if (i == 1) begin
                nchk++;
                if (stall_D !== 1'b1 || pending_map[5] !== 1'b1) begin
                    nerr++; $display("FAIL load_use_stall got=%b/%b exp=1/1", stall_D, pending_map[5]);
                end
            end
            if (i == 3) begin
                nchk++;
                if (stall_D !== 1'b0) begin nerr++; $display("FAIL load_use_wb_release got=%b exp=0", stall_D); end
            end
            if (i == 4) begin
                nchk++;
                if (pending_map !== 32'd0) begin nerr++; $display("FAIL load_use_clear got=%h exp=0", pending_map); end
            end
            adv();
        end
    endtask

    task automatic test_branch_ex();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(instr(0, 7, 0), 1, 1, 1, 0, 0, 1, 0, instr(7, 1, 2), 1, 0, 0, 0);
                1: drive(instr(0, 7, 0), 1, 1, 1, 0, 0, 1, 0, 32'd0, 0, 0, 0, 0);
                default: drive(instr(0, 7, 0), 1, 1, 0, 0, 0, 1, 0, instr(7, 1, 2), 1, 0, 0, 0);
            endcase
            #2; e = exp_q.pop_front(); nchk++;
            if (obs !== e) begin nerr++; $display("FAIL branch_ex[%0d] got=%h exp=%h", i, obs, e); end
            nchk++;
            if (stall_D !== (i == 0)) begin
                nerr++; $display("FAIL branch_ex_stall[%0d] got=%b exp=%b", i, stall_D, i == 0);
            end
            adv();
        end
    endtask

    task automatic test_x0();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(instr(0, 1, 0), 1, 0, 0, 1, 1, 1, 0, 32'd0, 0, 0, 0, 0);
                1: drive(instr(1, 0, 0), 1, 1, 1, 0, 1, 1, 0, instr(0, 3, 4), 1, 1, 1, 0);
                default: idle();
            endcase
            #2; e = exp_q.pop_front(); nchk++;
            if (obs !== e) begin nerr++; $display("FAIL x0[%0d] got=%h exp=%h", i, obs, e); end
            nchk++;
            if (stall_D !== 1'b0 || pending_map !== 32'd0) begin
                nerr++; $display("FAIL x0_quiet[%0d] got=%b/%h exp=0/0", i, stall_D, pending_map);
            end
            adv();
        end
    endtask

    task automatic test_waw();
        for (int i = 0; i < 10; i++) begin
            case (i)
                0, 1, 2, 3, 5: drive(instr(9, 1, 0), 1, 0, 0, 1, 1, 1, 0, 32'd0, 0, 0, 0, 0);
                4: drive(instr(9, 1, 0), 1, 0, 0, 1, 1, 1, 0, 32'd0, 0, 1, 1, 9);
                6, 7, 8: drive(32'd0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 1, 1, 9);
                default: idle();
            endcase
            #2; e = exp_q.pop_front(); nchk++;
            if (obs !== e) begin nerr++; $display("FAIL waw[%0d] got=%h exp=%h", i, obs, e); end
            if (i >= 3 && i <= 5) begin
                nchk++;
                if (stall_D !== (i != 5)) begin
                    nerr++; $display("FAIL waw_stall[%0d] got=%b exp=%b", i, stall_D, i != 5);
                end
            end
            adv();
        end
    endtask

    task automatic test_simul_underflow();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(instr(4, 0, 0), 0, 0, 0, 1, 1, 1, 0, 32'd0, 0, 0, 0, 0);
                1: drive(instr(4, 0, 0), 0, 0, 0, 1, 1, 1, 0, 32'd0, 0, 1, 1, 4);
                3, 4: drive(32'd0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 1, 1, 4);
                default: idle();
            endcase
            #2; e = exp_q.pop_front(); nchk++;
            if (obs !== e) begin nerr++; $display("FAIL simul_uflow[%0d] got=%h exp=%h", i, obs, e); end
            if (i == 2) begin
                nchk++;
                if (pending_map[4] !== 1'b1 || sb_err !== 1'b0) begin
                    nerr++; $display("FAIL simul_unchanged got=%b/%b exp=1/0", pending_map[4], sb_err);
                end
            end
            if (i >= 5) begin
                nchk++;
                if (sb_err !== 1'b1) begin nerr++; $display("FAIL uflow_sticky[%0d] got=%b exp=1", i, sb_err); end
            end
            adv();
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(instr(3, 0, 0), 0, 0, 0, 1, 1, 1, 1, 32'd0, 0, 0, 0, 0);
                2: drive(instr(3, 0, 0), 0, 0, 0, 1, 1, 1, 0, 32'd0, 0, 0, 0, 0);
                3: drive(instr(2, 0, 0), 0, 0, 0, 1, 1, 1, 0, 32'd0, 0, 0, 0, 0);
                4: drive(instr(6, 3, 2), 1, 1, 0, 0, 1, 1, 0, 32'd0, 0, 0, 0, 0);
                5: drive(32'd0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 1, 1, 3);
                default: idle();
            endcase
            #2; e = exp_q.pop_front(); nchk++;
            if (obs !== e) begin nerr++; $display("FAIL flush_reset[%0d] got=%h exp=%h", i, obs, e); end
            if (i == 0) begin
                nchk++;
                if (stall_D !== 1'b0) begin nerr++; $display("FAIL flush_stall got=%b exp=0", stall_D); end
            end
            if (i == 1) begin
                nchk++;
                if (pending_map[3] !== 1'b0) begin nerr++; $display("FAIL flush_noinc got=%b exp=0", pending_map[3]); end
            end
            if (i == 4) begin
                rst = 1'b1;
                #1;
                model_clear();
                nchk++;
                if (obs !== 50'd0) begin nerr++; $display("FAIL async_reset got=%h exp=0", obs); end
                adv();
                rst = 1'b0;
            end else begin
                adv();
            end
            if (i == 6) begin
                nchk++;
                if (sb_err !== 1'b1) begin nerr++; $display("FAIL post_reset_err got=%b exp=1", sb_err); end
            end
        end
    endtask

    task automatic test_perf_saturate();
        rst = 1'b1;
        #1;
        model_clear();
        adv();
        rst = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            drive(instr(0, 7, 0), 1, 0, 1, 0, 0, 1, 0, instr(7, 1, 2), 1, 0, 0, 0);
            #2; e = exp_q.pop_front(); nchk++;
            if (obs !== e) begin
                nerr++;
                if (nerr < 20) $display("FAIL perf[%0d] got=%h exp=%h", i, obs, e);
            end
            adv();
        end
        idle();
        #2; e = exp_q.pop_front(); nchk++;
        if (obs !== e) begin nerr++; $display("FAIL perf_final got=%h exp=%h", obs, e); end
        nchk++;
        if (stall_cycles !== 16'hFFFF) begin nerr++; $display("FAIL perf_sat got=%h exp=ffff", stall_cycles); end
        adv();
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        cur_stall = 1'b0;
        Instruction_IFID = '0; Instruction_IDEX = '0;
        uses_rs1_D = 0; uses_rs2_D = 0; is_branch_D = 0; is_long_D = 0; we_D = 0;
        issue_valid = 0; flush_D = 0; we_IDEX = 0; wb_valid = 0; wb_long = 0; wb_rd = '0;
        @(negedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_ex();
        test_x0();
        test_waw();
        test_simul_underflow();
        test_flush_reset();
        test_perf_saturate();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
